pc_sequencer: RTL and testbench

//  Fetch-PC controller for the 5-stage MIPS pipeline.
//  - Takes the decode-stage instruction and the branch unit's Branch/BLink decision.
//  - Sequences the fetch PC: sequential, branch, J/JAL or JR/JALR.
//  - Enforces the delay-slot rule and holds decode until branch operands are forwarded.
//  - Issues the $31/rd link write for linking branches and jumps.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/pc_target_calc.sv | 28 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, instruction classes and fetch-sequencer state type.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {RUN, WAIT_OPND, DSLOT} seq_state_t;

  typedef enum logic [1:0] {ClsSeq, ClsBr, ClsJmp, ClsJreg} instr_class_t;

  function automatic instr_class_t decode_class(input logic [5:0] opcode, input logic [5:0] funct);
    instr_class_t cls;
    cls = ClsSeq;
    case (opcode)
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = ClsBr;
      OP_J, OP_JAL:                                cls = ClsJmp;
      OP_SPECIAL: if (funct == FN_JR || funct == FN_JALR) cls = ClsJreg;
      default:                                     cls = ClsSeq;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational instruction-class decode and control-flow target selection.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [31:0]  id_instr_i,
  input  logic [31:0]  id_pc_i,
  input  logic [31:0]  jr_target_i,
  output instr_class_t instr_class_o,
  output logic [31:0]  target_o
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  always_comb begin
    instr_class_o = decode_class(id_instr_i[31:26], id_instr_i[5:0]);
    pc_plus4      = id_pc_i + 32'd4;
    br_off        = {{14{id_instr_i[15]}}, id_instr_i[15:0], 2'b00};
    target_o      = pc_plus4;
    unique case (instr_class_o)
      ClsBr:   target_o = pc_plus4 + br_off;
      ClsJmp:  target_o = {pc_plus4[31:28], id_instr_i[25:0], 2'b00};
      ClsJreg: target_o = jr_target_i;
      ClsSeq:  target_o = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: branch/jump redirect, delay-slot handling, operand wait and link write.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic        br_taken,
  input  logic        br_link,
  input  logic        operands_ready,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        id_hold,
  output logic        if_flush,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data
);

  seq_state_t   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         link_we_q, link_we_d;
  logic [4:0]   link_addr_q, link_addr_d;
  logic [31:0]  link_data_q, link_data_d;

  instr_class_t cls;
  logic [31:0]  target;
  logic         is_ctrl, resolved, taken, is_jalr, does_link;

  pc_target_calc u_target (
    .id_instr_i    (id_instr),
    .id_pc_i       (id_pc),
    .jr_target_i   (jr_target),
    .instr_class_o (cls),
    .target_o      (target)
  );

  always_comb begin
    is_ctrl   = id_valid && (cls != ClsSeq);
    resolved  = (cls == ClsJmp) || operands_ready;
    taken     = (cls == ClsBr) ? br_taken : 1'b1;
    is_jalr   = (cls == ClsJreg) && (id_instr[5:0] == FN_JALR);
    does_link = ((cls == ClsJmp) && (id_instr[31:26] == OP_JAL)) || is_jalr ||
                ((cls == ClsBr) && br_link);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      link_we_q   <= 1'b0;
      link_addr_q <= 5'd0;
      link_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      link_data_q <= link_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    link_we_d   = 1'b0;
    link_addr_d = link_addr_q;
    link_data_d = link_data_q;
    if (!stall) begin
      case (state_q)
        // The slot instruction always falls through, whatever it decodes as.
        DSLOT: begin
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
        default: begin
          if (!is_ctrl) begin
            pc_d    = pc_q + 32'd4;
            state_d = RUN;
          end else if (!resolved) begin
            state_d = WAIT_OPND;
          end else begin
            pc_d    = taken ? target : pc_q + 32'd4;
            state_d = DELAY_SLOT ? DSLOT : RUN;
            if (does_link) begin
              link_we_d   = 1'b1;
              link_addr_d = is_jalr ? id_instr[15:11] : LINK_REG;
              link_data_d = id_pc + 32'd8;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    id_hold  = !stall && (state_q != DSLOT) && is_ctrl && !resolved;
    if_flush = !DELAY_SLOT && !stall && (state_q != DSLOT) && is_ctrl && resolved && taken;
  end

  assign pc        = pc_q;
  assign link_we   = link_we_q;
  assign link_addr = link_addr_q;
  assign link_data = link_data_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one delay-slot instance and one flushing instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, id_valid, br_taken, br_link, operands_ready;
  logic [31:0] id_instr, id_pc, jr_target;

  logic [31:0] pc, pc0;
  logic        id_hold, id_hold0, if_flush, if_flush0, link_we, link_we0;
  logic [4:0]  link_addr, link_addr0;
  logic [31:0] link_data, link_data0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'hBFC0_0000), .DELAY_SLOT(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .br_taken       (br_taken),
    .br_link        (br_link),
    .operands_ready (operands_ready),
    .jr_target      (jr_target),
    .pc             (pc),
    .id_hold        (id_hold),
    .if_flush       (if_flush),
    .link_we        (link_we),
    .link_addr      (link_addr),
    .link_data      (link_data)
  );

  pc_sequencer #(.RESET_PC(32'hBFC0_0000), .DELAY_SLOT(1'b0)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .br_taken       (br_taken),
    .br_link        (br_link),
    .operands_ready (operands_ready),
    .jr_target      (jr_target),
    .pc             (pc0),
    .id_hold        (id_hold0),
    .if_flush       (if_flush0),
    .link_we        (link_we0),
    .link_addr      (link_addr0),
    .link_data      (link_data0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] ipc,
                       input logic tk, input logic lk, input logic rdy, input logic [31:0] jrt);
    id_valid       = v;
    id_instr       = instr;
    id_pc          = ipc;
    br_taken       = tk;
    br_link        = lk;
    operands_ready = rdy;
    jr_target      = jrt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BEQ3   = 32'h1022_0003;
  localparam logic [31:0] BEQM2  = 32'h1022_FFFE;
  localparam logic [31:0] BNE3   = 32'h1422_0003;
  localparam logic [31:0] J40    = 32'h0800_0040;
  localparam logic [31:0] JAL40  = 32'h0C00_0040;
  localparam logic [31:0] JR4    = 32'h0080_0008;
  localparam logic [31:0] JALR5  = 32'h0080_2809;
  localparam logic [31:0] BGEZAL = 32'h0491_0004;

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    drive(1'b0, NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Reset and free-running fetch
    step(); step();
    check_eq("rst_pc", pc, 32'hBFC0_0000);
    check_eq("rst_link_we", link_we, 1'b0);
    check_eq("rst_link_addr", link_addr, 5'd0);
    check_eq("rst_link_data", link_data, 32'h0);
    check_eq("rst_pc_nods", pc0, 32'hBFC0_0000);
    rst = 1'b0;
    step();
    check_eq("seq_pc1", pc, 32'hBFC0_0004);
    step();
    check_eq("seq_pc2", pc, 32'hBFC0_0008);
    check_eq("seq_link_we", link_we, 1'b0);

    // Taken BEQ, then a J sitting in the delay slot
    drive(1'b1, BEQ3, 32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    check_eq("beq_flush_ds", if_flush, 1'b0);
    check_eq("beq_flush_nods", if_flush0, 1'b1);
    check_eq("beq_hold", id_hold, 1'b0);
    step();
    check_eq("beq_pc", pc, 32'h110);
    check_eq("beq_pc_nods", pc0, 32'h110);
    drive(1'b1, J40, 32'h104, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("dslot_flush", if_flush, 1'b0);
    check_eq("j_flush_nods", if_flush0, 1'b1);
    step();
    check_eq("dslot_pc", pc, 32'h114);
    check_eq("j_pc_nods", pc0, 32'h100);

    // Not-taken BNE, J in its slot ignored
    drive(1'b1, BNE3, 32'h108, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("bne_flush_nods", if_flush0, 1'b0);
    step();
    check_eq("bne_pc", pc, 32'h118);
    drive(1'b1, J40, 32'h10C, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("bne_slot_j_pc", pc, 32'h11C);
    drive(1'b1, NOP, 32'h110, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("bne_after_pc", pc, 32'h120);

    // JAL: one-cycle link write to $31
    drive(1'b1, JAL40, 32'h2000_0008, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("jal_pc", pc, 32'h2000_0100);
    check_eq("jal_link_we", link_we, 1'b1);
    check_eq("jal_link_addr", link_addr, 5'd31);
    check_eq("jal_link_data", link_data, 32'h2000_0010);
    drive(1'b1, NOP, 32'h2000_000C, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("jal_slot_pc", pc, 32'h2000_0104);
    check_eq("jal_link_we_drop", link_we, 1'b0);
    step();
    check_eq("jal_run_pc", pc, 32'h2000_0108);

    // JR waiting two cycles on operands
    drive(1'b1, JR4, 32'h2000_0010, 1'b0, 1'b0, 1'b0, 32'h400);
    check_eq("jr_hold1", id_hold, 1'b1);
    step();
    check_eq("jr_wait_pc1", pc, 32'h2000_0108);
    check_eq("jr_hold2", id_hold, 1'b1);
    step();
    check_eq("jr_wait_pc2", pc, 32'h2000_0108);
    drive(1'b1, JR4, 32'h2000_0010, 1'b0, 1'b0, 1'b1, 32'h400);
    check_eq("jr_hold_rel", id_hold, 1'b0);
    step();
    check_eq("jr_pc", pc, 32'h400);
    check_eq("jr_no_link", link_we, 1'b0);
    drive(1'b1, NOP, 32'h2000_0014, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("jr_slot_pc", pc, 32'h404);

    // JALR links to rd
    drive(1'b1, JALR5, 32'h600, 1'b0, 1'b0, 1'b1, 32'h800);
    step();
    check_eq("jalr_pc", pc, 32'h800);
    check_eq("jalr_link_we", link_we, 1'b1);
    check_eq("jalr_link_addr", link_addr, 5'd5);
    check_eq("jalr_link_data", link_data, 32'h608);
    drive(1'b1, NOP, 32'h604, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("jalr_slot_pc", pc, 32'h804);
    check_eq("jalr_link_drop", link_we, 1'b0);

    // Backward branch offset
    drive(1'b1, BEQM2, 32'h1000, 1'b1, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("beq_back_pc", pc, 32'hFFC);
    drive(1'b1, NOP, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check_eq("beq_back_slot", pc, 32'h1000);

    // Stall over a taken BGEZAL, then stall inside its delay slot
    drive(1'b1, BGEZAL, 32'h500, 1'b1, 1'b1, 1'b1, 32'h0);
    stall = 1'b1;
    #1;
    check_eq("stall_hold", id_hold, 1'b0);
    check_eq("stall_flush_nods", if_flush0, 1'b0);
    step();
    check_eq("stall_pc1", pc, 32'h1000);
    check_eq("stall_link1", link_we, 1'b0);
    step();
    check_eq("stall_pc2", pc, 32'h1000);
    check_eq("stall_link2", link_we, 1'b0);
    stall = 1'b0;
    step();
    check_eq("bgezal_pc", pc, 32'h514);
    check_eq("bgezal_link_we", link_we, 1'b1);
    check_eq("bgezal_link_addr", link_addr, 5'd31);
    check_eq("bgezal_link_data", link_data, 32'h508);
    drive(1'b1, J40, 32'h504, 1'b0, 1'b0, 1'b1, 32'h0);
    stall = 1'b1;
    step();
    check_eq("dslot_stall_pc", pc, 32'h514);
    check_eq("dslot_stall_link", link_we, 1'b0);
    stall = 1'b0;
    step();
    check_eq("dslot_held_pc", pc, 32'h518);

    // Reset while waiting on operands
    drive(1'b1, JR4, 32'h700, 1'b0, 1'b0, 1'b0, 32'h900);
    step();
    check_eq("wait_pc", pc, 32'h518);
    rst = 1'b1;
    step();
    check_eq("rst_wait_pc", pc, 32'hBFC0_0000);
    check_eq("rst_wait_link", link_we, 1'b0);
    check_eq("rst_wait_pc_nods", pc0, 32'hBFC0_0000);
    rst = 1'b0;
    drive(1'b1, J40, 32'h104, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("rst_wait_hold", id_hold, 1'b0);
    step();
    check_eq("rst_run_j_pc", pc, 32'h100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
